// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV CSR scheduler, SRAM loader and SpMV core.
// Holds the scheduler state encoding and the default SRAM base addresses.
package spmv_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RP0,
        S_RP1,
        S_RPCAP,
        S_FETCH,
        S_VEC,
        S_VCAP,
        S_EMIT,
        S_DONE
    } spmv_state_e;

    // SRAM B holds row_ptr and col_idx; SRAM A holds values and the x vector.
    localparam int unsigned RP_BASE  = 0;
    localparam int unsigned CI_BASE  = 32;
    localparam int unsigned VAL_BASE = 0;
    localparam int unsigned VEC_BASE = 256;

endpackage

// File: rtl/spmv_csr_scheduler_if.sv
// Bus between the CSR scheduler, its two SRAM read ports and the SpMV core.
// The master modport is the scheduler side.
interface spmv_csr_scheduler_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned IDX_W  = 8
);

    logic              o_rd_en_a;
    logic [ADDR_W-1:0] o_rd_addr_a;
    logic [15:0]       i_rd_data_a;

    logic              o_rd_en_b;
    logic [ADDR_W-1:0] o_rd_addr_b;
    logic [15:0]       i_rd_data_b;

    logic              o_mac_valid;
    logic              i_mac_ready;
    logic [15:0]       o_mac_val;
    logic [15:0]       o_mac_x;
    logic [IDX_W-1:0]  o_mac_row;
    logic              o_mac_first;
    logic              o_mac_last;

    modport master (
        output o_rd_en_a, o_rd_addr_a,
        input  i_rd_data_a,
        output o_rd_en_b, o_rd_addr_b,
        input  i_rd_data_b,
        output o_mac_valid, o_mac_val, o_mac_x, o_mac_row, o_mac_first, o_mac_last,
        input  i_mac_ready
    );

    modport slave (
        input  o_rd_en_a, o_rd_addr_a,
        output i_rd_data_a,
        input  o_rd_en_b, o_rd_addr_b,
        output i_rd_data_b,
        input  o_mac_valid, o_mac_val, o_mac_x, o_mac_row, o_mac_first, o_mac_last,
        output i_mac_ready
    );

endinterface

// File: rtl/spmv_csr_scheduler.sv
// Walks a CSR matrix held in two 1-cycle-latency SRAMs and streams one
// (value, x, row, first/last) beat per nonzero to the SpMV core.
module spmv_csr_scheduler #(
    parameter int unsigned N_ROWS   = 16,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned RP_BASE  = spmv_pkg::RP_BASE,
    parameter int unsigned CI_BASE  = spmv_pkg::CI_BASE,
    parameter int unsigned VAL_BASE = spmv_pkg::VAL_BASE,
    parameter int unsigned VEC_BASE = spmv_pkg::VEC_BASE
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    spmv_csr_scheduler_if.master  bus
);

    import spmv_pkg::*;

    typedef logic [IDX_W-1:0] idx_t;

    spmv_state_e state, state_n;

    idx_t r;
    idx_t k;
    idx_t k_inc;
    idx_t rp_start;
    idx_t rp_end;
    idx_t rd_b_idx;

    logic [15:0] beat_val;
    logic [15:0] beat_x;
    idx_t        beat_row;
    logic        beat_first;
    logic        beat_last;
    logic        err_q;

    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              rd_en_a;
    logic              rd_en_b;

    logic handshake;
    logic more_rows;
    logic row_empty;
    logic row_bad;
    logic unused_rd_b_hi;

    assign rd_b_idx       = bus.i_rd_data_b[IDX_W-1:0];
    assign unused_rd_b_hi = ^bus.i_rd_data_b[15:IDX_W];
    assign k_inc          = k + idx_t'(1);

    // In RPCAP the live SRAM B word is row_ptr[r+1], i.e. the row end.
    assign row_empty = (rd_b_idx <= rp_start);
    assign row_bad   = (rd_b_idx <  rp_start);
    assign handshake = (state == S_EMIT) && bus.i_mac_ready;
    assign more_rows = (32'(r) + 32'd1) < N_ROWS;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Addresses are muxed live in the issuing state and otherwise replay the
    // held register, so they keep their last value between requests.
    always_comb begin
        state_n = state;
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
        addr_a  = addr_a_q;
        addr_b  = addr_b_q;
        unique case (state)
            S_IDLE: begin
                if (i_start) state_n = S_RP0;
            end
            S_RP0: begin
                rd_en_b = 1'b1;
                addr_b  = ADDR_W'(RP_BASE + 32'(r));
                state_n = S_RP1;
            end
            S_RP1: begin
                rd_en_b = 1'b1;
                addr_b  = ADDR_W'(RP_BASE + 32'(r) + 32'd1);
                state_n = S_RPCAP;
            end
            S_RPCAP: begin
                state_n = row_empty ? S_EMIT : S_FETCH;
            end
            S_FETCH: begin
                rd_en_a = 1'b1;
                rd_en_b = 1'b1;
                addr_a  = ADDR_W'(VAL_BASE + 32'(k));
                addr_b  = ADDR_W'(CI_BASE + 32'(k));
                state_n = S_VEC;
            end
            S_VEC: begin
                rd_en_a = 1'b1;
                addr_a  = ADDR_W'(VEC_BASE + 32'(rd_b_idx));
                state_n = S_VCAP;
            end
            S_VCAP: begin
                state_n = S_EMIT;
            end
            S_EMIT: begin
                if (handshake) begin
                    if (!beat_last)     state_n = S_FETCH;
                    else if (more_rows) state_n = S_RP0;
                    else                state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r          <= '0;
            k          <= '0;
            rp_start   <= '0;
            rp_end     <= '0;
            beat_val   <= '0;
            beat_x     <= '0;
            beat_row   <= '0;
            beat_first <= 1'b0;
            beat_last  <= 1'b0;
            err_q      <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
        end else begin
            addr_a_q <= addr_a;
            addr_b_q <= addr_b;
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        r     <= '0;
                        err_q <= 1'b0;
                    end
                end
                S_RP1: begin
                    rp_start <= rd_b_idx;
                end
                S_RPCAP: begin
                    rp_end <= rd_b_idx;
                    k      <= rp_start;
                    // A malformed (decreasing) row_ptr is flagged and the row
                    // is still emitted as an empty beat so the core stays in step.
                    if (row_empty) begin
                        beat_val   <= '0;
                        beat_x     <= '0;
                        beat_row   <= r;
                        beat_first <= 1'b1;
                        beat_last  <= 1'b1;
                    end
                    if (row_bad) err_q <= 1'b1;
                end
                S_VEC: begin
                    beat_val <= bus.i_rd_data_a;
                end
                S_VCAP: begin
                    beat_x     <= bus.i_rd_data_a;
                    beat_row   <= r;
                    beat_first <= (k == rp_start);
                    beat_last  <= (k_inc == rp_end);
                end
                S_EMIT: begin
                    if (handshake) begin
                        if (!beat_last)     k <= k_inc;
                        else if (more_rows) r <= r + idx_t'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy = (state != S_IDLE);
    assign o_done = (state == S_DONE);
    assign o_err  = err_q;

    assign bus.o_rd_en_a   = rd_en_a;
    assign bus.o_rd_addr_a = addr_a;
    assign bus.o_rd_en_b   = rd_en_b;
    assign bus.o_rd_addr_b = addr_b;

    assign bus.o_mac_valid = (state == S_EMIT);
    assign bus.o_mac_val   = beat_val;
    assign bus.o_mac_x     = beat_x;
    assign bus.o_mac_row   = beat_row;
    assign bus.o_mac_first = beat_first;
    assign bus.o_mac_last  = beat_last;

endmodule

// File: doc/spmv_csr_scheduler.md
# spmv_csr_scheduler

Sequencer that walks a CSR sparse matrix stored across the two 16-bit SRAM read ports and feeds the SpMV core one nonzero at a time. SRAM B holds row_ptr and col_idx; SRAM A holds matrix values and the input vector. For each nonzero it fetches col_idx and value, gathers the matching vector element, and presents a (value, vector, row, first/last) beat to the core over a valid/ready handshake. It replaces ad-hoc per-buffer start strobes with a single controller driven by i_start.

## Interface
- N_ROWS, 16: number of matrix rows; row_ptr has N_ROWS+1 entries.
- ADDR_W, 10: SRAM address width.
- IDX_W, 8: width of nonzero index k and of col_idx used for vector lookup.
- RP_BASE, 0: SRAM B word address of row_ptr[0].
- CI_BASE, 32: SRAM B word address of col_idx[0].
- VAL_BASE, 0: SRAM A word address of value[0].
- VEC_BASE, 256: SRAM A word address of x[0].

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_start  in  1  start pulse; ignored unless idle.
- o_busy  out  1  high whenever state is not IDLE.
- o_done  out  1  one-cycle pulse after the last beat is accepted.
- o_err  out  1  sticky malformed-row_ptr flag; cleared on next accepted i_start.
- o_rd_en_a / o_rd_addr_a  out  1 / ADDR_W  SRAM A read request.
- i_rd_data_a  in  16  SRAM A data, valid the cycle after the request.
- o_rd_en_b / o_rd_addr_b  out  1 / ADDR_W  SRAM B read request.
- i_rd_data_b  in  16  SRAM B data, 1-cycle latency.
- o_mac_valid  out  1  beat valid.
- i_mac_ready  in  1  core accepts the beat.
- o_mac_val  out  16  matrix value (0 for an empty-row beat).
- o_mac_x  out  16  vector element (0 for an empty-row beat).
- o_mac_row  out  IDX_W  row index.
- o_mac_first / o_mac_last  out  1  first / last beat of the row.

## Operation
- States: IDLE, RP0, RP1, RPCAP, FETCH, VEC, VCAP, EMIT, DONE.
- IDLE, on i_start: clear r, clear o_err, go to RP0.
- RP0: issue B read at RP_BASE+r.
- RP1: capture start=i_rd_data_b; issue B read at RP_BASE+r+1.
- RPCAP: capture end=i_rd_data_b; set k=start.
  - If end==start, go to EMIT as an empty-row beat: val=0, x=0, first=last=1.
  - If end<start, set o_err and treat the row as empty.
  - Otherwise go to FETCH.
- FETCH: issue B read at CI_BASE+k and A read at VAL_BASE+k in the same cycle.
- VEC: capture val=i_rd_data_a; issue A read at VEC_BASE+i_rd_data_b[IDX_W-1:0].
- VCAP: capture x=i_rd_data_a. Set first=(k==start) and last=(k+1==end).
- EMIT: o_mac_valid held high; all beat fields stay stable until the handshake. On valid&&ready:
  - if not last: k++ and go to FETCH;
  - else if r+1<N_ROWS: r++ and go to RP0;
  - else go to DONE.
- DONE: pulse o_done, return to IDLE.
- Arithmetic:
  - Addresses are base+offset truncated to ADDR_W.
  - k and the row_ptr values use their low IDX_W bits.
  - Comparisons are unsigned on IDX_W bits.
- Read enables are high only in RP0, RP1, FETCH and VEC. Addresses hold their last value otherwise.

## Timing
- Reset: state IDLE; all outputs 0, including o_err, addresses and beat fields.
- Reset mid-operation aborts immediately. No o_done pulse is produced.
- Edge numbering: the edge that samples i_start is E0.
  - First RP0 cycle follows E0.
  - o_mac_valid first rises after E6 when row 0 is non-empty.
  - When row 0 is empty, o_mac_valid rises after E3.
- Steady state with ready held high: one beat every 4 cycles within a row. A row change adds 3 cycles (RP0, RP1, RPCAP).
- i_mac_ready low stalls in EMIT indefinitely with no SRAM traffic.
- i_start while busy is ignored, including in the DONE cycle.
- Exactly one o_done per completed run, on the cycle after the final handshake.

## Structure
- The shared package spmv_pkg holds:
  - the state enum type;
  - default base-address constants RP_BASE, CI_BASE, VAL_BASE and VEC_BASE, shared with the SRAM loader and SpMV core.
- Single module with no sub-modules. The beat register and the FSM are small enough to keep flat.

## Test plan
- Dense 2x2 matrix: row_ptr={0,2,4}, col_idx={0,1,0,1}, val={1,2,3,4}, x={5,6}, ready tied high.
  - Expect 4 beats (1,5,r0,F), (2,6,r0,L), (3,5,r1,F), (4,6,r1,L).
  - Then o_done exactly 1 cycle after the last beat.
- Empty middle row: row_ptr={0,1,1,2}, N_ROWS=3.
  - Row 1 beat has val=0, x=0, first=last=1.
  - First beat appears after E6; total beats = 3.
- Backpressure: hold i_mac_ready low for 10 cycles on beat 2.
  - Beat fields stay stable; no o_rd_en_a or o_rd_en_b during the stall.
  - Sequence is unchanged.
- Malformed row_ptr: row_ptr={0,3,2}.
  - o_err set and sticky; row 1 emitted as an empty beat; run still completes with o_done.
  - Next i_start clears o_err.
- Control corner cases:
  - i_start pulsed during EMIT and during DONE is ignored.
  - Reset asserted during FETCH forces all outputs to 0 and IDLE immediately; no o_done follows.
- Address wrap: VEC_BASE=1020, ADDR_W=10, col_idx=5 → o_rd_addr_a=1.
